alsu_cmd_issuer: RTL and testbench

ALSU_CMD_ISSUER -- requirements
Module: alsu_cmd_issuer

---
 rtl/alsu_cmd_issuer_pkg.sv | 28 ++
 rtl/alsu_cmd_issuer_if.sv | 37 +++
 rtl/alsu_cmd_fifo.sv | 57 +++++
 rtl/alsu_cmd_issuer.sv | 108 ++++++++++
 tb/tb_alsu_cmd_issuer.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alsu_cmd_issuer_pkg.sv
// Shared types and constants for the ALSU command issuer.
package alsu_cmd_issuer_pkg;

   localparam int SEL_W  = 5;
   localparam int DATA_W = 4;
   localparam int CMD_W  = SEL_W + 2 * DATA_W;

   // Operation groups carried in cmd_sel[4:3]
   localparam logic [1:0] GRP_LOGIC = 2'b00;
   localparam logic [1:0] GRP_INV   = 2'b01;
   localparam logic [1:0] GRP_CMP   = 2'b10;
   localparam logic [1:0] GRP_SHIFT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_CAPTURE,
      ST_HOLD
   } issuer_state_t;

   // One queued command, packed as {sel, a, b}
   typedef struct packed {
      logic [SEL_W-1:0]  sel;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } alsu_cmd_t;

endpackage

// File: rtl/alsu_cmd_issuer_if.sv
// Command, ALSU and response signals of the issuer, bundled as one interface.
// The master modport is the issuer's view; the slave modport is the view of
// the surrounding environment (command source, ALSU and response consumer).
interface alsu_cmd_issuer_if #(
   parameter int TAG_W = 4
);
   import alsu_cmd_issuer_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [SEL_W-1:0]  cmd_sel;
   logic [DATA_W-1:0] cmd_a;
   logic [DATA_W-1:0] cmd_b;

   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [SEL_W-1:0]  alu_sel;
   logic [DATA_W-1:0] alu_out;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic [TAG_W-1:0]  rsp_tag;

   logic              busy;

   modport master (
      input  cmd_valid, cmd_sel, cmd_a, cmd_b, alu_out, rsp_ready,
      output cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_tag, busy
   );

   modport slave (
      output cmd_valid, cmd_sel, cmd_a, cmd_b, alu_out, rsp_ready,
      input  cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_tag, busy
   );

endinterface

// File: rtl/alsu_cmd_fifo.sv
// Small synchronous FIFO holding pending {sel, a, b} commands.
// Full/empty come from the registered count only, so a pop in the same
// cycle never opens space for a push into a full FIFO.
module alsu_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 13
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth)
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/alsu_cmd_issuer.sv
// Queues ALSU commands, launches them one at a time onto registered ALSU
// inputs, captures the combinational result and hands it out with a
// sequence tag. One response every three cycles when never back-pressured.
module alsu_cmd_issuer
   import alsu_cmd_issuer_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int TAG_W      = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   alsu_cmd_issuer_if.master    bus
);

   issuer_state_t    state;
   issuer_state_t    next_state;
   alsu_cmd_t        head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             push;
   logic             pop;
   logic             capture;
   logic             release_rsp;
   logic [TAG_W-1:0] tag_cnt;

   assign bus.cmd_ready = ~fifo_full & ~rst;
   assign push          = bus.cmd_valid & bus.cmd_ready;
   assign bus.busy      = ~fifo_empty | (state != ST_IDLE);

   alsu_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (CMD_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata ({bus.cmd_sel, bus.cmd_a, bus.cmd_b}),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= next_state;
   end

   // Next-state logic and the per-state pop/capture/release strobes
   always_comb begin
      next_state  = state;
      pop         = 1'b0;
      capture     = 1'b0;
      release_rsp = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!fifo_empty) next_state = ST_LAUNCH;
         end
         ST_LAUNCH: begin
            pop        = 1'b1;
            next_state = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            capture    = 1'b1;
            next_state = ST_HOLD;
         end
         ST_HOLD: begin
            if (bus.rsp_ready) begin
               release_rsp = 1'b1;
               next_state  = fifo_empty ? ST_IDLE : ST_LAUNCH;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // ALSU operand registers, loaded only while launching so they stay quiet otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.alu_sel <= '0;
         bus.alu_a   <= '0;
         bus.alu_b   <= '0;
      end else if (pop) begin
         bus.alu_sel <= head.sel;
         bus.alu_a   <= head.a;
         bus.alu_b   <= head.b;
      end
   end

   // Response capture, tag counter and the valid flag held until the consumer takes it
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.rsp_valid <= 1'b0;
         bus.rsp_data  <= '0;
         bus.rsp_tag   <= '0;
         tag_cnt       <= '0;
      end else if (capture) begin
         bus.rsp_valid <= 1'b1;
         bus.rsp_data  <= bus.alu_out;
         bus.rsp_tag   <= tag_cnt;
         tag_cnt       <= tag_cnt + TAG_W'(1);
      end else if (release_rsp) begin
         bus.rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alsu_cmd_issuer.sv
// Self-checking bench for alsu_cmd_issuer with a stand-in ALSU and an
// in-order response scoreboard.
module tb_alsu_cmd_issuer;
   import alsu_cmd_issuer_pkg::*;

   localparam int TAG_W      = 4;
   localparam int FIFO_DEPTH = 4;

   typedef struct {
      logic [3:0]       data;
      logic [TAG_W-1:0] tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   alsu_cmd_issuer_if #(.TAG_W(TAG_W)) bus ();

   alsu_cmd_issuer #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .TAG_W      (TAG_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t             exp_q[$];
   int               tag_model;
   int               checks;
   int               passed;
   int               failed;
   int               cyc;
   int               n_xfer;
   int               first_xfer;
   int               last_xfer;
   logic [TAG_W-1:0] last_tag;
   logic [4:0]       s;
   logic [3:0]       a;
   logic [3:0]       b;

   // Stand-in ALSU: one behaviour per group/op
   function automatic logic [3:0] alsu_model(input logic [4:0] sel, input logic [3:0] x, input logic [3:0] y);
      logic [3:0] r;
      r = 4'h0;
      case (sel[4:3])
         GRP_LOGIC: case (sel[1:0])
            2'd0: r = x & y;
            2'd1: r = x | y;
            2'd2: r = x ^ y;
            default: r = ~(x ^ y);
         endcase
         GRP_INV: case (sel[1:0])
            2'd0: r = ~(x & y);
            2'd1: r = ~(x | y);
            default: r = ~x;
         endcase
         GRP_CMP: case (sel[1:0])
            2'd0: r = x;
            2'd1: r = {3'b000, x == y};
            default: r = {3'b000, $signed(x) < $signed(y)};
         endcase
         default: case (sel[1:0])
            2'd0: r = {x[2:0], 1'b0};
            2'd1: r = {1'b0, x[3:1]};
            2'd2: r = {x[2:0], x[3]};
            default: r = {x[0], x[3:1]};
         endcase
      endcase
      return r;
   endfunction

   // Combinational ALSU seen by the issuer
   always_comb bus.alu_out = alsu_model(bus.alu_sel, bus.alu_a, bus.alu_b);

   task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed=%0h expected=%0h", name, obs, expv);
      end
   endtask

   task automatic flagFail(input string name);
      checks++;
      failed++;
      $error("FAIL %s: observed=timeout/unexpected expected=event", name);
   endtask

   // Record this cycle's handshakes in the model, then advance one clock
   task automatic step();
      exp_t e;
      if (rst) begin
         exp_q.delete();
         tag_model = 0;
      end else begin
         if (bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) flagFail("unexpected_rsp");
            else begin
               e = exp_q.pop_front();
               checkOutput("rsp_data", 32'(bus.rsp_data), 32'(e.data));
               checkOutput("rsp_tag", 32'(bus.rsp_tag), 32'(e.tag));
               last_tag = bus.rsp_tag;
               if (n_xfer == 0) first_xfer = cyc;
               last_xfer = cyc;
               n_xfer++;
            end
         end
         if (bus.cmd_valid && bus.cmd_ready) begin
            e.data = alsu_model(bus.cmd_sel, bus.cmd_a, bus.cmd_b);
            e.tag  = TAG_W'(tag_model);
            exp_q.push_back(e);
            tag_model++;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic applyStimulus(input logic [4:0] sel, input logic [3:0] x, input logic [3:0] y);
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      bus.cmd_valid = 1'b1;
      bus.cmd_sel   = sel;
      bus.cmd_a     = x;
      bus.cmd_b     = y;
      while (!done && n < 100) begin
         if (bus.cmd_ready) done = 1'b1;
         step();
         n++;
      end
      if (!done) flagFail("cmd_accept_timeout");
      bus.cmd_valid = 1'b0;
   endtask

   task automatic waitRspValid();
      int n;
      n = 0;
      while (!bus.rsp_valid && n < 50) begin
         step();
         n++;
      end
      if (!bus.rsp_valid) flagFail("rsp_valid_timeout");
   endtask

   task automatic drain();
      int n;
      n = 0;
      bus.rsp_ready = 1'b1;
      while (exp_q.size() != 0 && n < 300) begin
         step();
         n++;
      end
      if (exp_q.size() != 0) flagFail("drain_timeout");
   endtask

   task automatic doReset();
      rst = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      checks = 0; passed = 0; failed = 0; cyc = 0;
      tag_model = 0; n_xfer = 0; first_xfer = 0; last_xfer = 0; last_tag = '0;
      bus.cmd_valid = 1'b0;
      bus.cmd_sel   = '0;
      bus.cmd_a     = '0;
      bus.cmd_b     = '0;
      bus.rsp_ready = 1'b0;

      // Reset state, sampled while rst is still high
      rst = 1'b1;
      step();
      step();
      checkOutput("reset_cmd_ready", 32'(bus.cmd_ready), 0);
      checkOutput("reset_busy", 32'(bus.busy), 0);
      checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 0);
      checkOutput("reset_rsp_data", 32'(bus.rsp_data), 0);
      checkOutput("reset_rsp_tag", 32'(bus.rsp_tag), 0);
      checkOutput("reset_alu", 32'({bus.alu_sel, bus.alu_a, bus.alu_b}), 0);
      rst = 1'b0;
      #1;
      checkOutput("cmd_ready_after_reset", 32'(bus.cmd_ready), 1);

      // Single AND command: valid exactly three edges after acceptance
      bus.rsp_ready = 1'b1;
      applyStimulus(5'b00000, 4'hC, 4'hA);
      checkOutput("busy_after_accept", 32'(bus.busy), 1);
      checkOutput("lat_edge1", 32'(bus.rsp_valid), 0);
      step();
      checkOutput("lat_edge2", 32'(bus.rsp_valid), 0);
      step();
      checkOutput("lat_edge3", 32'(bus.rsp_valid), 0);
      step();
      checkOutput("lat_valid", 32'(bus.rsp_valid), 1);
      checkOutput("and_data", 32'(bus.rsp_data), 32'h8);
      checkOutput("and_tag", 32'(bus.rsp_tag), 0);
      step();
      checkOutput("valid_clears", 32'(bus.rsp_valid), 0);

      // ALU inputs hold while idle
      for (int i = 0; i < 5; i++) step();
      checkOutput("alu_idle_hold", 32'({bus.alu_sel, bus.alu_a, bus.alu_b}), 32'({5'b00000, 4'hC, 4'hA}));
      checkOutput("idle_busy", 32'(bus.busy), 0);

      // Backpressure: ten cycles of rsp_ready low in HOLD
      bus.rsp_ready = 1'b0;
      s = 5'($urandom); a = 4'($urandom); b = 4'($urandom);
      applyStimulus(s, a, b);
      waitRspValid();
      for (int i = 0; i < 10; i++) begin
         step();
         checkOutput("hold_stable",
                     32'({bus.rsp_valid, bus.rsp_data, bus.rsp_tag, bus.alu_sel, bus.alu_a, bus.alu_b}),
                     32'({1'b1, alsu_model(s, a, b), 4'd1, s, a, b}));
      end
      drain();

      // Fill: five back-to-back pushes with no consumer, then a sixth held off
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) applyStimulus(5'($urandom), 4'($urandom), 4'($urandom));
      checkOutput("full_cmd_ready", 32'(bus.cmd_ready), 0);
      bus.cmd_valid = 1'b1;
      s = 5'($urandom); a = 4'($urandom); b = 4'($urandom);
      bus.cmd_sel = s; bus.cmd_a = a; bus.cmd_b = b;
      for (int i = 0; i < 3; i++) begin
         step();
         checkOutput("full_held_off", 32'(bus.cmd_ready), 0);
      end
      bus.rsp_ready = 1'b1;
      applyStimulus(s, a, b);
      drain();

      // Group sweep: one op per group, a=5 b=3
      for (int g = 0; g < 4; g++) begin
         bus.rsp_ready = 1'b0;
         s = {2'(g), 3'($urandom_range(0, 7))};
         applyStimulus(s, 4'h5, 4'h3);
         waitRspValid();
         checkOutput("sweep_alu_sel", 32'(bus.alu_sel), 32'(s));
         checkOutput("sweep_alu_ab", 32'({bus.alu_a, bus.alu_b}), 32'h53);
         checkOutput("sweep_data", 32'(bus.rsp_data), 32'(alsu_model(s, 4'h5, 4'h3)));
         bus.rsp_ready = 1'b1;
         step();
      end
      step();
      step();

      // Reset mid-flight: three queued, reset lands while the first is in CAPTURE
      bus.rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus(5'($urandom), 4'($urandom), 4'($urandom));
      checkOutput("pre_reset_valid", 32'(bus.rsp_valid), 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      checkOutput("midrst_valid", 32'(bus.rsp_valid), 0);
      checkOutput("midrst_busy", 32'(bus.busy), 0);
      checkOutput("midrst_cmd_ready", 32'(bus.cmd_ready), 1);
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         checkOutput("midrst_no_rsp", 32'(bus.rsp_valid), 0);
      end
      applyStimulus(5'($urandom), 4'($urandom), 4'($urandom));
      waitRspValid();
      checkOutput("midrst_new_tag", 32'(bus.rsp_tag), 0);
      drain();

      // Tag wrap and sustained throughput with consumer always ready
      doReset();
      n_xfer = 0;
      bus.rsp_ready = 1'b1;
      for (int i = 0; i < 17; i++) applyStimulus(5'($urandom), 4'($urandom), 4'($urandom));
      drain();
      checkOutput("wrap_count", 32'(n_xfer), 17);
      checkOutput("wrap_last_tag", 32'(last_tag), 0);
      checkOutput("throughput_span", 32'(last_xfer - first_xfer), 48);

      // Random traffic with random backpressure
      for (int i = 0; i < 80; i++) begin
         bus.cmd_valid = 1'($urandom);
         bus.cmd_sel   = 5'($urandom);
         bus.cmd_a     = 4'($urandom);
         bus.cmd_b     = 4'($urandom);
         bus.rsp_ready = 1'($urandom);
         step();
      end
      bus.cmd_valid = 1'b0;
      drain();
      step();
      step();
      checkOutput("final_busy", 32'(bus.busy), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
